// File: rtl/apb_timer_event_unit_if.sv
// APB bus bundle shared between a master (CPU/bridge) and the timer event unit.
interface apb_timer_event_unit_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_timer_event_unit.sv
// Rising-edge event capture for the timer's event bus: sticky pending/overrun flags,
// saturating per-event counters and one maskable registered interrupt behind an APB slave.
module apb_timer_event_unit #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int EVT_NUM        = 4,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  apb_timer_event_unit_if.slave apb,
  input  logic [EVT_NUM-1:0]  events_i,
  output logic                irq_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [EVT_NUM-1:0]   evt_q_reg;
  logic [EVT_NUM-1:0]   evt_en_reg;
  logic [EVT_NUM-1:0]   irq_mask_reg;
  logic [EVT_NUM-1:0]   pend_reg, pend_next;
  logic [EVT_NUM-1:0]   ovr_reg, ovr_next;
  logic [CNT_WIDTH-1:0] cnt_reg  [EVT_NUM];
  logic [CNT_WIDTH-1:0] cnt_next [EVT_NUM];
  logic                 irq_reg;

  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [2:0]  offset;
  logic        access;
  logic        addr_err;
  logic        wr_en;
  logic        wr_evt_en, wr_irq_mask, wr_status, wr_count;
  logic [31:0] rd_data;
  logic [31:0] en_word, mask_word, status_word, count_word, raw_word;
  logic        addr_data_unused;

  assign paddr    = apb.PADDR;
  assign offset   = paddr[4:2];
  assign access   = apb.PSEL & apb.PENABLE;
  assign addr_err = (offset >= 3'd5);
  assign wr_en    = access & apb.PWRITE & ~addr_err;

  assign wr_evt_en   = wr_en & (offset == 3'd0);
  assign wr_irq_mask = wr_en & (offset == 3'd1);
  assign wr_status   = wr_en & (offset == 3'd2);
  assign wr_count    = wr_en & (offset == 3'd3);

  // Only part of the address/data buses is decoded; fold the rest away explicitly.
  assign addr_data_unused = ^{paddr, apb.PWDATA};

  genvar gi;
  generate
    for (gi = 0; gi < EVT_NUM; gi++) begin : g_evt
      logic                 edge_det;
      logic                 w1c_pend;
      logic                 w1c_ovr;
      logic [CNT_WIDTH-1:0] cnt_base;

      assign edge_det = events_i[gi] & ~evt_q_reg[gi] & evt_en_reg[gi];
      assign w1c_pend = wr_status & apb.PWDATA[gi];
      assign w1c_ovr  = wr_status & apb.PWDATA[4+gi];

      // A new edge beats a simultaneous clear; overrun only when the old flag survives.
      assign pend_next[gi] = edge_det | (pend_reg[gi] & ~w1c_pend);
      assign ovr_next[gi]  = (edge_det & pend_reg[gi] & ~w1c_pend) | (ovr_reg[gi] & ~w1c_ovr);

      // Counter clear happens first so a coincident edge leaves the count at one.
      assign cnt_base     = wr_count ? '0 : cnt_reg[gi];
      assign cnt_next[gi] = (edge_det && (cnt_base != CNT_MAX)) ? (cnt_base + CNT_ONE) : cnt_base;
    end
  endgenerate

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      evt_q_reg    <= '0;
      evt_en_reg   <= '0;
      irq_mask_reg <= '0;
      pend_reg     <= '0;
      ovr_reg      <= '0;
      irq_reg      <= 1'b0;
      for (int i = 0; i < EVT_NUM; i++) begin
        cnt_reg[i] <= '0;
      end
    end else begin
      evt_q_reg <= events_i;
      pend_reg  <= pend_next;
      ovr_reg   <= ovr_next;
      irq_reg   <= |(pend_reg & irq_mask_reg);
      if (wr_evt_en) begin
        evt_en_reg <= apb.PWDATA[EVT_NUM-1:0];
      end
      if (wr_irq_mask) begin
        irq_mask_reg <= apb.PWDATA[EVT_NUM-1:0];
      end
      for (int i = 0; i < EVT_NUM; i++) begin
        cnt_reg[i] <= cnt_next[i];
      end
    end
  end

  always_comb begin
    en_word     = '0;
    mask_word   = '0;
    status_word = '0;
    count_word  = '0;
    raw_word    = '0;
    en_word[EVT_NUM-1:0]     = evt_en_reg;
    mask_word[EVT_NUM-1:0]   = irq_mask_reg;
    status_word[EVT_NUM-1:0] = pend_reg;
    status_word[4 +: EVT_NUM] = ovr_reg;
    raw_word[EVT_NUM-1:0]    = events_i;
    for (int i = 0; i < EVT_NUM; i++) begin
      count_word[i*CNT_WIDTH +: CNT_WIDTH] = cnt_reg[i];
    end
  end

  always_comb begin
    rd_data = '0;
    case (offset)
      3'd0:    rd_data = en_word;
      3'd1:    rd_data = mask_word;
      3'd2:    rd_data = status_word;
      3'd3:    rd_data = count_word;
      3'd4:    rd_data = raw_word;
      default: rd_data = '0;
    endcase
  end

  assign apb.PRDATA  = apb.PSEL ? rd_data : 32'h0;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = access & addr_err;
  assign irq_o       = irq_reg;

endmodule
